// File: rtl/mem_if_pkg.sv
// mem_if_pkg
// Shared definitions for the cache-to-memory line interface: line width,
// the byte-address bit range that mem_addr carries, the responder state
// encoding and the latched operation encoding.
package mem_if_pkg;

  localparam int LINE_W     = 128;
  localparam int ADDR_HI    = 31;
  localparam int ADDR_LO    = 4;
  localparam int MEM_ADDR_W = ADDR_HI - ADDR_LO + 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  typedef enum logic {
    OP_RD,
    OP_WR
  } op_t;

endpackage

// File: rtl/line_ram.sv
// line_ram
// Single-port 2^ADDR_W x DATA_W synchronous RAM with a registered read port.
// Kept as its own module so a technology RAM macro can be swapped in.
// Ports:
//   clk    - rising-edge clock
//   rst    - synchronous active-high reset of the read register only
//   rd_en  - load rdata from mem[addr] at the next edge
//   wr_en  - write wdata into mem[addr] at the next edge
//   addr   - line index
//   wdata  - write line data
//   rdata  - registered read data; holds until the next enabled read
module line_ram
  import mem_if_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = LINE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // The array itself has no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[addr] <= wdata;
    end
  end

  // The read register only changes on an explicit read, so the last read
  // response stays visible while writes go through the same port.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (rd_en) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/slow_mem_responder.sv
// slow_mem_responder
// Memory-side responder for a cache line interface. Accepts one read or
// write request at a time and completes it with a one-cycle mem_ready pulse
// exactly LATENCY cycles after the accept cycle.
// Ports:
//   clk          - rising-edge clock
//   proc_reset   - synchronous active-high reset
//   mem_read     - line read request, held until mem_ready
//   mem_write    - line write request, held until mem_ready
//   mem_addr     - line address (byte address bits [31:4])
//   mem_wdata    - write line data
//   mem_rdata    - read line data, valid in the mem_ready cycle of a read
//   mem_ready    - one-cycle completion pulse
//   busy         - high while a request is in flight (WAIT or RESP)
//   protocol_err - sticky protocol violation flag, cleared by reset
module slow_mem_responder
  import mem_if_pkg::*;
#(
  parameter int LATENCY = 8,
  parameter int ADDR_W  = 10
) (
  input  logic                  clk,
  input  logic                  proc_reset,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [MEM_ADDR_W-1:0] mem_addr,
  input  logic [LINE_W-1:0]     mem_wdata,
  output logic [LINE_W-1:0]     mem_rdata,
  output logic                  mem_ready,
  output logic                  busy,
  output logic                  protocol_err
);

  state_t                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  op_t                   op_q;
  logic [1:0]            req_q;
  logic [MEM_ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0]     wdata_q;
  logic                  err_q, err_d;
  logic                  accept;
  logic                  ram_rd;
  logic                  ram_wr;
  logic [ADDR_W-1:0]     ram_addr;

  // State, counter and error flag; reset drops any request in flight.
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Request capture. The full address and the raw read/write pair are kept
  // so that any change while the request is pending can be flagged.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q    <= mem_write ? OP_WR : OP_RD;
      req_q   <= {mem_read, mem_write};
      addr_q  <= mem_addr;
      wdata_q <= mem_wdata;
    end
  end

  // Next-state and RAM control. The RAM read is issued in the cycle before
  // RESP so that the registered read data lands exactly on the RESP edge.
  // In IDLE the RAM sees the live address because with LATENCY==1 the read
  // must be issued on the accept edge itself.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    accept    = 1'b0;
    ram_rd    = 1'b0;
    ram_wr    = 1'b0;
    ram_addr  = addr_q[ADDR_W-1:0];
    mem_ready = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        ram_addr = mem_addr[ADDR_W-1:0];
        if (mem_read || mem_write) begin
          accept = 1'b1;
          cnt_d  = 8'(LATENCY - 1);
          if (mem_read && mem_write) begin
            err_d = 1'b1;
          end
          if (LATENCY == 1) begin
            state_d = RESP;
            ram_rd  = mem_read && !mem_write;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        busy = 1'b1;
        if (!mem_read && !mem_write) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
          if ({mem_read, mem_write} != req_q || mem_addr != addr_q) begin
            err_d = 1'b1;
          end
          if (cnt_q == 8'd1) begin
            state_d = RESP;
            ram_rd  = (op_q == OP_RD);
          end
        end
      end
      RESP: begin
        busy      = 1'b1;
        mem_ready = 1'b1;
        ram_wr    = (op_q == OP_WR);
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign protocol_err = err_q;

  // A reset on the edge ending RESP must not commit the write.
  line_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (LINE_W)
  ) u_line_ram (
    .clk   (clk),
    .rst   (proc_reset),
    .rd_en (ram_rd),
    .wr_en (ram_wr && !proc_reset),
    .addr  (ram_addr),
    .wdata (wdata_q),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_slow_mem_responder.sv
// tb_slow_mem_responder
// Directed bench for slow_mem_responder: one instance with LATENCY=8 and one
// with LATENCY=1, both with ADDR_W=10. Expected values are hand-computed
// constants.
module tb_slow_mem_responder;

  logic         clk = 1'b0;
  logic         proc_reset;
  logic         rd0, wr0, rd1, wr1;
  logic [27:0]  addr0, addr1;
  logic [127:0] wdata0, wdata1, rdata0, rdata1;
  logic         ready0, ready1, busy0, busy1, err0, err1;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_ready = 0;

  localparam logic [127:0] DATA_A5 = {16{8'hA5}};
  localparam logic [127:0] DATA_C  = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] DATA_F  = {128{1'b1}};
  localparam logic [127:0] DATA_D1 = 128'hD1D1_0000_1111_2222_3333_4444_5555_6666;
  localparam logic [127:0] DATA_X  = 128'h5050_5050_0000_0000_0000_0000_0000_0050;
  localparam logic [127:0] DATA_Y  = 128'h6060_6060_0000_0000_0000_0000_0000_0060;
  localparam logic [127:0] DATA_P  = 128'h3030_CAFE_0000_0000_0000_0000_0000_0030;
  localparam logic [127:0] DATA_Q  = 128'h3131_BEEF_0000_0000_0000_0000_0000_0031;
  localparam logic [127:0] DATA_Z  = 128'h0400_0400_DEAD_BEEF_0000_0000_0000_0400;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  slow_mem_responder #(.LATENCY(8), .ADDR_W(10)) dut8 (
    .clk          (clk),
    .proc_reset   (proc_reset),
    .mem_read     (rd0),
    .mem_write    (wr0),
    .mem_addr     (addr0),
    .mem_wdata    (wdata0),
    .mem_rdata    (rdata0),
    .mem_ready    (ready0),
    .busy         (busy0),
    .protocol_err (err0)
  );

  slow_mem_responder #(.LATENCY(1), .ADDR_W(10)) dut1 (
    .clk          (clk),
    .proc_reset   (proc_reset),
    .mem_read     (rd1),
    .mem_write    (wr1),
    .mem_addr     (addr1),
    .mem_wdata    (wdata1),
    .mem_rdata    (rdata1),
    .mem_ready    (ready1),
    .busy         (busy1),
    .protocol_err (err1)
  );

  task automatic checkOutput(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int sel, input logic rd, input logic wr,
                       input logic [27:0] a, input logic [127:0] d);
    if (sel == 0) begin
      rd0 = rd; wr0 = wr; addr0 = a; wdata0 = d;
    end else begin
      rd1 = rd; wr1 = wr; addr1 = a; wdata1 = d;
    end
  endtask

  // Steps until the selected responder pulses mem_ready; lat counts edges
  // from the call, so a call made in the accept cycle yields the latency.
  task automatic waitReady(input int sel, output int lat);
    logic got;
    got = 1'b0;
    lat = 0;
    while (!got && lat < 300) begin
      step();
      lat++;
      if ((sel == 0) ? ready0 : ready1) got = 1'b1;
    end
    checkOutput("resp_seen", 128'(got), 128'(1));
    last_ready = cyc;
  endtask

  // Full transfer: raise the request, wait for mem_ready, drop the request
  // inside the RESP cycle and return in the following IDLE cycle.
  task automatic applyStimulus(input int sel, input logic rd, input logic wr,
                               input logic [27:0] a, input logic [127:0] d,
                               output int lat, output logic [127:0] rdata);
    drive(sel, rd, wr, a, d);
    waitReady(sel, lat);
    rdata = (sel == 0) ? rdata0 : rdata1;
    drive(sel, 1'b0, 1'b0, a, d);
    step();
    checkOutput("ready_one_cycle", 128'((sel == 0) ? ready0 : ready1), 128'(0));
    checkOutput("busy_after_resp", 128'((sel == 0) ? busy0 : busy1), 128'(0));
  endtask

  initial begin
    int lat;
    int t0;
    int t1;
    int seen;
    logic [127:0] rd;

    proc_reset = 1'b1;
    drive(0, 1'b0, 1'b0, 28'h0, 128'h0);
    drive(1, 1'b0, 1'b0, 28'h0, 128'h0);
    repeat (2) step();
    checkOutput("reset_ready", 128'(ready0), 128'(0));
    checkOutput("reset_rdata", rdata0, 128'(0));
    checkOutput("reset_busy", 128'(busy0), 128'(0));
    checkOutput("reset_err", 128'(err0), 128'(0));
    proc_reset = 1'b0;
    step();

    // Preload and read back with LATENCY=8.
    applyStimulus(0, 1'b0, 1'b1, 28'h0000010, DATA_A5, lat, rd);
    checkOutput("wr_latency", 128'(lat), 128'(8));
    applyStimulus(0, 1'b1, 1'b0, 28'h0000010, 128'h0, lat, rd);
    checkOutput("rd_latency", 128'(lat), 128'(8));
    checkOutput("rd_data_a5", rd, DATA_A5);
    t0 = last_ready;

    // Back-to-back write then read of the same line.
    applyStimulus(0, 1'b0, 1'b1, 28'h0000020, DATA_C, lat, rd);
    checkOutput("rdata_hold_on_write", rd, DATA_A5);
    t1 = last_ready;
    checkOutput("turnaround_wr", 128'(t1 - t0), 128'(9));
    applyStimulus(0, 1'b1, 1'b0, 28'h0000020, 128'h0, lat, rd);
    checkOutput("raw_data", rd, DATA_C);
    checkOutput("turnaround_rd", 128'(last_ready - t1), 128'(9));

    // Abort a write after three cycles.
    drive(0, 1'b0, 1'b1, 28'h0000020, DATA_F);
    repeat (3) step();
    drive(0, 1'b0, 1'b0, 28'h0000020, DATA_F);
    seen = 0;
    repeat (12) begin
      step();
      if (ready0) seen++;
    end
    checkOutput("abort_no_ready", 128'(seen), 128'(0));
    checkOutput("abort_busy", 128'(busy0), 128'(0));
    checkOutput("abort_err", 128'(err0), 128'(0));
    applyStimulus(0, 1'b1, 1'b0, 28'h0000020, 128'h0, lat, rd);
    checkOutput("abort_old_data", rd, DATA_C);

    // Read and write together: treated as a write, error flagged.
    applyStimulus(0, 1'b1, 1'b1, 28'h0000040, DATA_D1, lat, rd);
    checkOutput("both_latency", 128'(lat), 128'(8));
    checkOutput("both_err", 128'(err0), 128'(1));
    applyStimulus(0, 1'b1, 1'b0, 28'h0000040, 128'h0, lat, rd);
    checkOutput("both_wrote", rd, DATA_D1);

    proc_reset = 1'b1;
    step();
    proc_reset = 1'b0;
    checkOutput("err_cleared", 128'(err0), 128'(0));

    // Address change during WAIT: response uses the original line.
    applyStimulus(0, 1'b0, 1'b1, 28'h0000050, DATA_X, lat, rd);
    applyStimulus(0, 1'b0, 1'b1, 28'h0000060, DATA_Y, lat, rd);
    checkOutput("no_err_yet", 128'(err0), 128'(0));
    drive(0, 1'b1, 1'b0, 28'h0000050, 128'h0);
    repeat (3) step();
    drive(0, 1'b1, 1'b0, 28'h0000060, 128'h0);
    waitReady(0, lat);
    checkOutput("chg_latency", 128'(lat + 3), 128'(8));
    checkOutput("chg_rdata", rdata0, DATA_X);
    checkOutput("chg_err", 128'(err0), 128'(1));
    drive(0, 1'b0, 1'b0, 28'h0000060, 128'h0);
    step();

    // Reset in the middle of a write: nothing committed.
    applyStimulus(0, 1'b0, 1'b1, 28'h0000030, DATA_P, lat, rd);
    drive(0, 1'b0, 1'b1, 28'h0000030, DATA_Q);
    repeat (3) step();
    proc_reset = 1'b1;
    step();
    checkOutput("rst_mid_ready", 128'(ready0), 128'(0));
    checkOutput("rst_mid_busy", 128'(busy0), 128'(0));
    checkOutput("rst_mid_err", 128'(err0), 128'(0));
    checkOutput("rst_mid_rdata", rdata0, 128'(0));
    proc_reset = 1'b0;
    drive(0, 1'b0, 1'b0, 28'h0000030, 128'h0);
    step();
    applyStimulus(0, 1'b1, 1'b0, 28'h0000030, 128'h0, lat, rd);
    checkOutput("rst_mid_old_line", rd, DATA_P);

    // LATENCY=1 instance: aliasing and single-cycle response.
    applyStimulus(1, 1'b0, 1'b1, 28'h0000400, DATA_Z, lat, rd);
    checkOutput("l1_wr_latency", 128'(lat), 128'(1));
    t0 = last_ready;
    applyStimulus(1, 1'b1, 1'b0, 28'h0000000, 128'h0, lat, rd);
    checkOutput("l1_rd_latency", 128'(lat), 128'(1));
    checkOutput("alias_data", rd, DATA_Z);
    checkOutput("l1_turnaround", 128'(last_ready - t0), 128'(2));
    checkOutput("l1_err", 128'(err1), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/slow_mem_responder.md
Name: slow_mem_responder

Overview:
- Memory-side responder for the 128-bit line interface driven by dcache_wrapper and icache_wrapper (mem_read/mem_write/mem_addr/mem_wdata → mem_rdata/mem_ready).
- Holds a synthesizable line array and answers each cache request after a fixed, parameterized latency.
- One instance per cache; it replaces the behavioural slow memory in FPGA/emulation builds and serves as the reference responder in cache unit benches.

Parameters:
- LATENCY, 8, number of cycles from request acceptance to the mem_ready cycle; legal values are 1..255.
- ADDR_W, 10, line-index width; the array holds 2^ADDR_W lines of 128 bits.

Ports:
- clk  input  1  system clock, rising edge.
- proc_reset  input  1  synchronous, active-high reset.
- mem_read  input  1  line read request; held high until mem_ready is seen.
- mem_write  input  1  line write request; held high until mem_ready is seen.
- mem_addr  input  28  line address [31:4].
- mem_wdata  input  128  write line data.
- mem_rdata  output  128  read line data; valid in the mem_ready cycle of a read.
- mem_ready  output  1  one-cycle completion pulse.
- busy  output  1  high in WAIT and RESP.
- protocol_err  output  1  sticky error flag; cleared only by reset.

Behaviour:
- Reset values: mem_ready=0, mem_rdata=0, busy=0, protocol_err=0, state=IDLE, counter=0. The array contents are not reset. Reset in any state aborts the request and commits no write.
- States: IDLE, WAIT, RESP.
- IDLE:
  - If mem_read|mem_write is high, accept the request: latch op, mem_addr[ADDR_W+3:4] as the index, and mem_wdata.
  - Load counter=LATENCY-1. Go to RESP if LATENCY==1, otherwise go to WAIT.
  - Address bits above ADDR_W+3 are ignored, so addresses alias (wrap).
- Both mem_read and mem_write high at acceptance: treat as a write and set protocol_err.
- WAIT:
  - Decrement counter each cycle. Go to RESP when counter reaches 1, so mem_ready is high exactly LATENCY cycles after the accept cycle.
  - If both mem_read and mem_write drop: abort to IDLE, with no response, no write commit, and no error.
  - If mem_addr or the op changes while the request stays high: set protocol_err and continue with the latched values.
- RESP:
  - mem_ready=1 for exactly this one cycle.
  - Read: mem_rdata is updated at the edge entering RESP from the latched index. It holds that value until the next read response; writes do not change it.
  - Write: the array line is written at the edge ending RESP.
  - Next state is always IDLE.
- Turnaround: the cache drops its request on the edge where it samples mem_ready. A request seen in the IDLE cycle after RESP is a new request, so back-to-back transfers cost LATENCY+1 cycles each.
- Read-after-write to the same line returns the newly written data, because the commit edge precedes the next accept.
- mem_ready is never asserted outside RESP and never for two consecutive cycles.
- Counter width is 8 bits; it has no wrap concerns given the LATENCY range.

Decomposition:
- Shared package (mem_if_pkg) holds:
  - LINE_W=128 and ADDR_HI=31/ADDR_LO=4 constants;
  - the state enum {IDLE, WAIT, RESP};
  - the op encoding {OP_RD, OP_WR}.
- One natural sub-module, line_ram: a single-port 2^ADDR_W x 128 synchronous RAM with registered read and write enable. It lets a technology macro replace the RAM. The FSM and counter stay in the top module.

Test Plan:
- Read latency: LATENCY=8, preload line 0x010=0xA5A5...A5, hold mem_read with mem_addr=0x0000010 → mem_ready high exactly 8 cycles after accept, for one cycle, with mem_rdata=0xA5A5...A5; busy=0 the following cycle.
- Write then read: write 0x0123...CDEF to mem_addr=0x0000020, then read the same address immediately after mem_ready → read returns 0x0123...CDEF; each transfer takes 9 cycles including turnaround.
- Abort: assert mem_write for 3 cycles, then drop it → no mem_ready, the line is unchanged, protocol_err=0, and the next read returns the old data.
- Protocol violation: mem_read and mem_write both high → protocol_err=1 and the write completes; separately, changing mem_addr mid-WAIT → protocol_err=1 and the response uses the original address.
- Reset mid-WAIT of a write to 0x0000030 → no commit, all outputs 0 the next cycle, and the line keeps its old value.
- Aliasing and LATENCY=1: with ADDR_W=10, writing mem_addr=0x0000400 lands on line 0x000; with LATENCY=1, mem_ready is high in the cycle after accept.
